// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {S_CPU, S_AUX} dmem_arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the MEM stage and an auxiliary requester.
// CPU has priority; an aging counter bounds the aux wait, and the pipeline stalls during aux slots.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = dmem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W   = dmem_arb_pkg::DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_mem_read_i,
  input  logic              cpu_mem_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              aux_req_i,
  input  logic              aux_we_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [DATA_W-1:0] aux_wdata_i,
  output logic              aux_ack_o,
  output logic [DATA_W-1:0] aux_rdata_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);
  import dmem_arb_pkg::*;

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(MAX_WAIT);

  dmem_arb_state_t  state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             cpu_active;
  logic             aux_sel;

  assign cpu_active = cpu_mem_read_i | cpu_mem_write_i;
  assign aux_sel    = (state_q == S_AUX);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_CPU: begin
        if (aux_req_i && (!cpu_active || wait_q == WaitLast)) begin
          state_d = S_AUX;
        end else if (aux_req_i && cpu_active && wait_q != WaitMax) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_AUX: begin
        // Always hand back to the CPU so it gets at least one cycle between aux slots.
        state_d = S_CPU;
        wait_d  = '0;
      end
      default: begin
        state_d = S_CPU;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_CPU;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Stall and ack decode from the registered state, so aux_req never reaches cpu_stall.
  always_comb begin
    mem_address_o    = cpu_addr_i;
    mem_write_data_o = cpu_wdata_i;
    mem_read_o       = cpu_mem_read_i;
    mem_write_o      = cpu_mem_write_i;
    cpu_stall_o      = 1'b0;
    aux_ack_o        = 1'b0;
    if (aux_sel) begin
      mem_address_o    = aux_addr_i;
      mem_write_data_o = aux_wdata_i;
      mem_read_o       = aux_req_i & ~aux_we_i;
      mem_write_o      = aux_req_i & aux_we_i;
      cpu_stall_o      = cpu_active;
      aux_ack_o        = aux_req_i;
    end
  end

  assign cpu_rdata_o = mem_read_data_i;
  assign aux_rdata_o = mem_read_data_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// compared against a cycle-level behavioural model and a reference memory image.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst_ni;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wd;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        aux_req, aux_we;
  logic [31:0] aux_addr, aux_wd;
  logic        aux_ack;
  logic [31:0] aux_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .cpu_mem_read_i  (cpu_rd),
    .cpu_mem_write_i (cpu_wr),
    .cpu_addr_i      (cpu_addr),
    .cpu_wdata_i     (cpu_wd),
    .cpu_rdata_o     (cpu_rdata),
    .cpu_stall_o     (cpu_stall),
    .aux_req_i       (aux_req),
    .aux_we_i        (aux_we),
    .aux_addr_i      (aux_addr),
    .aux_wdata_i     (aux_wd),
    .aux_ack_o       (aux_ack),
    .aux_rdata_o     (aux_rdata),
    .mem_address_o   (mem_address),
    .mem_write_data_o(mem_write_data),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .mem_read_data_i (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Environment data memory: combinational read, write on rising edge.
  bit          mem_init;
  logic [31:0] env_mem [256];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= seed_word(i);
      mem_init <= 1'b1;
    end else if (mem_write) begin
      env_mem[mem_address[9:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = env_mem[mem_address[9:2]];

  // Reference model: which agent owns this cycle, how long aux has waited, expected memory image.
  logic [31:0] ref_mem [256];
  bit          m_aux_turn;
  int          m_waited;
  bit          exp_ack, exp_stall;
  logic        obs_ack, obs_stall, obs_mw, obs_mr;
  logic [31:0] obs_addr, obs_cpu_rdata, obs_aux_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven after a falling edge.
  task automatic cycle();
    logic       act;
    logic [7:0] ci, ai;
    #1;
    act = cpu_rd | cpu_wr;
    ci  = cpu_addr[9:2];
    ai  = aux_addr[9:2];
    obs_ack = aux_ack; obs_stall = cpu_stall; obs_mw = mem_write; obs_mr = mem_read;
    obs_addr = mem_address; obs_cpu_rdata = cpu_rdata; obs_aux_rdata = aux_rdata;
    if (m_aux_turn) begin
      exp_ack   = aux_req;
      exp_stall = act;
      chkb("aux_slot_ack", aux_ack, aux_req);
      chkb("aux_slot_stall", cpu_stall, act);
      chkb("aux_slot_mem_read", mem_read, aux_req & ~aux_we);
      chkb("aux_slot_mem_write", mem_write, aux_req & aux_we);
      if (aux_req) chk("aux_slot_addr", mem_address, aux_addr);
      if (aux_req && aux_we) chk("aux_slot_wdata", mem_write_data, aux_wd);
      if (aux_req && !aux_we) chk("aux_rdata", aux_rdata, ref_mem[ai]);
    end else begin
      exp_ack   = 1'b0;
      exp_stall = 1'b0;
      chkb("cpu_slot_ack", aux_ack, 1'b0);
      chkb("cpu_slot_stall", cpu_stall, 1'b0);
      chkb("cpu_slot_mem_read", mem_read, cpu_rd);
      chkb("cpu_slot_mem_write", mem_write, cpu_wr);
      chk("cpu_slot_addr", mem_address, cpu_addr);
      if (cpu_wr) chk("cpu_slot_wdata", mem_write_data, cpu_wd);
      if (cpu_rd) chk("cpu_rdata", cpu_rdata, ref_mem[ci]);
    end
    @(posedge clk);
    if (m_aux_turn) begin
      if (aux_req && aux_we) ref_mem[ai] = aux_wd;
      m_aux_turn = 1'b0;
      m_waited   = 0;
    end else begin
      if (cpu_wr) ref_mem[ci] = cpu_wd;
      if (aux_req && (!act || m_waited + 1 >= MAX_WAIT)) m_aux_turn = 1'b1;
      else if (aux_req && act) m_waited++;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    return {22'b0, 8'($urandom), 2'b00};
  endfunction

  initial begin
    rst_ni = 1'b0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wd = 32'h0;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h0; aux_wd = 32'h0;
    m_aux_turn = 1'b0; m_waited = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    #2;
    chkb("reset_ack", aux_ack, 1'b0);
    chkb("reset_stall", cpu_stall, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cpu_rd = 1'b0; aux_req = 1'b0;
    rst_ni = 1'b1;

    // Reset asserted while the aux owns the memory.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h200; aux_wd = 32'h1234_5678;
    cycle();
    cpu_rd = 1'b1; cpu_addr = 32'h8;
    #1;
    chkb("pre_reset_ack", aux_ack, 1'b1);
    chkb("pre_reset_stall", cpu_stall, 1'b1);
    rst_ni = 1'b0;
    #1;
    chkb("async_reset_ack", aux_ack, 1'b0);
    chkb("async_reset_stall", cpu_stall, 1'b0);
    chkb("async_reset_mem_write", mem_write, 1'b0);
    chk("async_reset_addr", mem_address, 32'h8);
    @(posedge clk);
    @(negedge clk);
    cpu_rd = 1'b0; aux_req = 1'b0;
    rst_ni = 1'b1;
    m_aux_turn = 1'b0; m_waited = 0;

    // CPU idle: aux write acked in cycle 1, then CPU reads it back.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h40; aux_wd = 32'hDEAD_BEEF;
    cycle();
    chkb("t2_c0_ack", obs_ack, 1'b0);
    cycle();
    chkb("t2_c1_ack", obs_ack, 1'b1);
    chkb("t2_c1_mem_write", obs_mw, 1'b1);
    chk("t2_c1_addr", obs_addr, 32'h40);
    aux_req = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h40;
    cycle();
    chk("t2_cpu_load", obs_cpu_rdata, 32'hDEAD_BEEF);

    // CPU loads every cycle; aux read of 0x80 granted only after MAX_WAIT cycles.
    for (int k = 0; k < 6; k++) begin
      cpu_rd = 1'b1;
      if (k <= 4) cpu_addr = 32'h100 + 32'(4 * k);
      aux_req = (k <= 4); aux_we = 1'b0; aux_addr = 32'h80;
      cycle();
      chkb("t3_ack", obs_ack, k == 4);
      chkb("t3_stall", obs_stall, k == 4);
      if (k == 4) chk("t3_aux_rdata", obs_aux_rdata, seed_word(32));
      if (k == 5) chk("t3_stalled_load", obs_cpu_rdata, seed_word(32'h110 / 4));
    end

    // Continuously held aux read with an idle CPU alternates acks.
    cpu_rd = 1'b0;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h84;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chkb("t4_ack", obs_ack, k % 2 == 1);
      chkb("t4_stall", obs_stall, 1'b0);
    end
    aux_req = 1'b0;
    cycle();

    // Competing stores to 0x10: CPU first, aux later, aux value survives.
    cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wd = 32'h11;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h10; aux_wd = 32'h22;
    cycle();
    chkb("t5_c0_ack", obs_ack, 1'b0);
    chkb("t5_c0_cpu_write", obs_mw, 1'b1);
    cpu_wr = 1'b0;
    cycle();
    cycle();
    chkb("t5_aux_ack", obs_ack, 1'b1);
    aux_req = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h10;
    cycle();
    chk("t5_final", obs_cpu_rdata, 32'h22);
    cpu_rd = 1'b0;

    // aux_req withdrawn during its slot: no access, no ack.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h20; aux_wd = 32'hBAD0_BAD0;
    cycle();
    aux_req = 1'b0;
    cycle();
    chkb("t6_mem_write", obs_mw, 1'b0);
    chkb("t6_mem_read", obs_mr, 1'b0);
    chkb("t6_ack", obs_ack, 1'b0);
    aux_req = 1'b1; aux_we = 1'b0;
    cycle();
    chkb("t6_back_in_cpu", obs_ack, 1'b0);
    cycle();
    chkb("t6_regrant", obs_ack, 1'b1);
    aux_req = 1'b0;
    cycle();

    // Randomized traffic obeying both protocols.
    exp_ack = 1'b0; exp_stall = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!exp_stall) begin
        int op;
        op = int'($urandom_range(0, 3));
        cpu_rd = (op == 1) || (op == 3);
        cpu_wr = (op == 2);
        cpu_addr = rand_addr();
        cpu_wd = $urandom;
      end
      if (!aux_req || exp_ack) begin
        aux_req = ($urandom_range(0, 2) == 0);
        aux_we = 1'($urandom);
        aux_addr = rand_addr();
        aux_wd = $urandom;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
